base_acredit_src: RTL and testbench

- Credit-based link transmitter; sits directly upstream of the credit sink FIFO stage.
- Accepts beats from a local ready/valid producer and forwards them over a non-backpressured valid/data link.
- Sends only while it holds credits; each returned credit pulse from the sink restores one credit.
- Provides link-idle and sticky overflow-error status for quiesce and debug logic.

---
 rtl/base_acredit_cnt.sv | 42 ++++
 rtl/base_vlat.sv | 20 ++
 rtl/base_acredit_src.sv | 73 +++++++
 tb/tb_base_acredit_src.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/base_acredit_cnt.sv
// Up/down credit counter that saturates at credits and resets full.
// ovf flags a return arriving while already full with nothing consumed.
module base_acredit_cnt #(
    parameter int credits   = 8,
    parameter int cnt_width = $clog2(credits + 1)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 dec,
    input  logic                 inc,
    output logic [cnt_width-1:0] cnt,
    output logic                 nz,
    output logic                 full,
    output logic                 ovf
);

    localparam logic [cnt_width-1:0] max_cnt = cnt_width'(credits);

    logic [cnt_width-1:0] cnt_next;

    assign nz   = (cnt != '0);
    assign full = (cnt == max_cnt);
    assign ovf  = inc & ~dec & full;

    always_comb begin
        cnt_next = cnt;
        if (inc && !dec && !full) begin
            cnt_next = cnt + 1'b1;
        end else if (dec && !inc && nz) begin
            cnt_next = cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= max_cnt;
        end else begin
            cnt <= cnt_next;
        end
    end

endmodule

// File: rtl/base_vlat.sv
// Plain register stage with asynchronous active-low clear.
// Used as the link output register that holds {valid, data}.
module base_vlat #(
    parameter int width = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/base_acredit_src.sv
// Credit-based link transmitter: forwards ready/valid beats onto a
// non-backpressured valid/data link while credits remain.
module base_acredit_src #(
    parameter int credits   = 8,
    parameter int cnt_width = $clog2(credits + 1),
    parameter int width     = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_v,
    output logic             i_r,
    input  logic [0:width-1] i_d,
    output logic             o_v,
    output logic [0:width-1] o_d,
    input  logic             o_c,
    output logic             idle,
    output logic             err
);

    logic [cnt_width-1:0] cnt;
    logic                 nz;
    logic                 full;
    logic                 ovf;
    logic                 send;
    logic [width:0]       out_d;
    logic [width:0]       out_q;
    logic                 unused_cnt;

    base_acredit_cnt #(
        .credits  (credits),
        .cnt_width(cnt_width)
    ) u_cnt (
        .clk  (clk),
        .reset(reset),
        .dec  (send),
        .inc  (o_c),
        .cnt  (cnt),
        .nz   (nz),
        .full (full),
        .ovf  (ovf)
    );

    assign unused_cnt = ^cnt;

    // i_r comes only from the registered count, so o_c cannot reach it same-cycle.
    assign i_r  = nz;
    assign send = i_v & nz;

    // Data bits hold their last value when no beat is taken.
    assign out_d = {send, send ? i_d : o_d};

    base_vlat #(
        .width(width + 1)
    ) u_out (
        .clk  (clk),
        .reset(reset),
        .d    (out_d),
        .q    (out_q)
    );

    assign o_v  = out_q[width];
    assign o_d  = out_q[width-1:0];
    assign idle = full & ~o_v;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            err <= 1'b0;
        end else if (ovf) begin
            err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_base_acredit_src.sv
// Scoreboard bench for base_acredit_src: stimulus queues expected beats,
// a negedge monitor pops and compares whenever o_v is presented.
module tb_base_acredit_src;

    localparam int CR = 8;
    localparam int W  = 8;

    logic         clk   = 1'b0;
    logic         reset = 1'b0;
    logic         i_v   = 1'b0;
    logic         o_c   = 1'b0;
    logic [0:W-1] i_d   = '0;
    logic         i_r;
    logic         o_v;
    logic [0:W-1] o_d;
    logic         idle;
    logic         err;

    int           tests = 0;
    int           fails = 0;
    logic [W-1:0] sbq[$];
    logic [W-1:0] mon_exp;
    int           mcnt;
    bit           merr;

    base_acredit_src #(
        .credits(CR),
        .width  (W)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .i_v  (i_v),
        .i_r  (i_r),
        .i_d  (i_d),
        .o_v  (o_v),
        .o_d  (o_d),
        .o_c  (o_c),
        .idle (idle),
        .err  (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented beat must match the oldest queued expectation.
    initial begin
        forever begin
            @(negedge clk);
            if (o_v === 1'b1) begin
                if (sbq.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL o_v_unexpected: got beat %0h expected no beat at %0t", o_d, $time);
                end else begin
                    mon_exp = sbq.pop_front();
                    chk("o_d", 32'(o_d), 32'(mon_exp));
                end
            end
        end
    end

    // One clock of stimulus, entered and left at a falling edge.
    task automatic cycle(input bit v, input logic [W-1:0] d, input bit c);
        bit send;
        i_v = v;
        i_d = d;
        o_c = c;
        send = v && (mcnt != 0);
        if (send) sbq.push_back(d);
        @(posedge clk);
        #1;
        if (c && !send && mcnt == CR) merr = 1'b1;
        else mcnt = mcnt - int'(send) + int'(c);
        chk("i_r", 32'(i_r), 32'(mcnt != 0));
        chk("idle", 32'(idle), 32'((mcnt == CR) && !send));
        chk("err", 32'(err), 32'(merr));
        chk("o_v", 32'(o_v), 32'(send));
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mcnt = CR;
        merr = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_i_r", 32'(i_r), 32'd1);
        chk("rst_idle", 32'(idle), 32'd1);
        chk("rst_o_v", 32'(o_v), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b1;
        cycle(1'b0, 8'h00, 1'b0);

        // Burst of 10 offered beats: only 8 fit the credit window
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(i), 1'b0);

        // Single credit return while starved: exactly one more beat (0x08)
        cycle(1'b1, 8'h08, 1'b1);
        cycle(1'b1, 8'h08, 1'b0);
        cycle(1'b1, 8'h09, 1'b0);

        // cnt=1 with simultaneous send and return: count holds
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b1, 8'hA5, 1'b1);
        cycle(1'b1, 8'h5C, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

        // Overflow at full: err sticks through later traffic
        cycle(1'b0, 8'h00, 1'b1);
        cycle(1'b0, 8'h00, 1'b0);
        for (int i = 0; i < 4; i++) cycle(1'b1, 8'(8'h10 + i), 1'b0);

        // Fifth send leaves cnt=3 with a beat on the output, then async reset
        i_v = 1'b1;
        i_d = 8'h5A;
        o_c = 1'b0;
        @(posedge clk);
        #1;
        chk("o_v_inflight", 32'(o_v), 32'd1);
        chk("err_held", 32'(err), 32'd1);
        chk("i_r_inflight", 32'(i_r), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("arst_o_v", 32'(o_v), 32'd0);
        chk("arst_idle", 32'(idle), 32'd1);
        chk("arst_i_r", 32'(i_r), 32'd1);
        chk("arst_err", 32'(err), 32'd0);
        mcnt = CR;
        merr = 1'b0;
        i_v  = 1'b0;
        @(negedge clk);
        reset = 1'b1;

        // Normal sending resumes from a full credit window
        for (int i = 0; i < 10; i++) cycle(1'b1, 8'(8'hC0 + i), 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 8'h00, 1'b1);

        repeat (2) @(negedge clk);
        chk("scoreboard_empty", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
